// File: rtl/seq_det_pkg.sv
// Types shared by the serial sequence detector blocks: FSM state encoding for the feeder.
// Pure declarations; no latency or flow control of its own.
package seq_det_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_state_e;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detector; first bit on dataout 1 cycle after transfer.
// din_ready only in IDLE or on the last-bit bit_en tick, so back-to-back words stream with no gap.
module serial_bit_feeder
  import seq_det_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   LSB_FIRST = 1'b0,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             dataout,
  output logic             dataout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  seq_state_e       state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             armed;
  logic             load, advance, go_idle;
  logic             load_bit, next_bit;

  // shreg holds the bits still to be shown; the current bit already sits in dataout
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (LSB_FIRST) shift_once = {1'b0, v[WIDTH-1:1]};
    else           shift_once = {v[WIDTH-2:0], 1'b0};
  endfunction

  assign load_bit = LSB_FIRST ? din[0]   : din[WIDTH-1];
  assign next_bit = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  assign busy     = (state == ST_SHIFT);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    go_idle   = 1'b0;
    din_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        din_ready = armed;
        if (armed && din_valid) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_en) begin
          if (cnt == LAST_IDX) begin
            din_ready = 1'b1;
            if (din_valid) begin
              load = 1'b1;
            end else begin
              go_idle   = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // armed keeps din_ready low during reset and lets it rise one edge after release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      shreg         <= '0;
      cnt           <= '0;
      armed         <= 1'b0;
      dataout       <= IDLE_BIT;
      dataout_valid <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_nxt;
      if (load) begin
        shreg         <= shift_once(din);
        dataout       <= load_bit;
        dataout_valid <= 1'b1;
        frame_start   <= 1'b1;
        cnt           <= '0;
      end else if (advance) begin
        shreg       <= shift_once(shreg);
        dataout     <= next_bit;
        frame_start <= 1'b0;
        cnt         <= cnt + 1'b1;
      end else if (go_idle) begin
        shreg         <= '0;
        dataout       <= IDLE_BIT;
        dataout_valid <= 1'b0;
        frame_start   <= 1'b0;
        cnt           <= '0;
      end
    end
  end

endmodule
